// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: per-channel duty with period-boundary shadowing,
// programmable prescaler and a period-start strobe, written via a byte register port.
module pwm_bank #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [5:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] ch_out,
  output logic              period_start
);

  localparam int unsigned MAX      = (1 << CNT_W) - 1;
  localparam int unsigned NUM_BYTE = NUM_CH / 8;

  logic [NUM_CH-1:0] r_out_en;
  logic [NUM_CH-1:0] r_pwm_mode;
  logic [7:0]        r_prescale;
  logic [7:0]        r_div_cnt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_duty_pending [NUM_CH];
  logic [CNT_W-1:0]  r_duty_active  [NUM_CH];
  logic [NUM_CH-1:0] r_ch_out;
  logic              r_period_start;

  logic w_tick;
  logic w_wrap;

  // >= rather than == so a prescale lowered below div_cnt still ticks next cycle
  assign w_tick = (r_div_cnt >= r_prescale);
  assign w_wrap = w_tick && (r_count == CNT_W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_en       <= '0;
      r_pwm_mode     <= '0;
      r_prescale     <= '0;
      r_div_cnt      <= '0;
      r_count        <= '0;
      r_ch_out       <= '0;
      r_period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_pending[i] <= '0;
        r_duty_active[i]  <= '0;
      end
    end else begin
      r_div_cnt      <= w_tick ? 8'(0) : r_div_cnt + 8'(1);
      r_period_start <= w_wrap;

      if (w_tick) begin
        r_count <= w_wrap ? CNT_W'(0) : r_count + CNT_W'(1);
      end

      // Duty shadow copy happens only at the period boundary
      if (w_wrap) begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_duty_active[i] <= r_duty_pending[i];
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        r_ch_out[i] <= r_out_en[i] & (r_pwm_mode[i] ? (r_count < r_duty_active[i]) : 1'b1);
      end

      if (wr_en) begin
        for (int k = 0; k < NUM_BYTE; k++) begin
          if (wr_addr == 6'(k))     r_out_en[8*k +: 8]   <= wr_data;
          if (wr_addr == 6'(4 + k)) r_pwm_mode[8*k +: 8] <= wr_data;
        end
        if (wr_addr == 6'h08) r_prescale <= wr_data;
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_addr == 6'(32 + i)) r_duty_pending[i] <= wr_data[CNT_W-1:0];
        end
      end
    end
  end

  assign ch_out       = r_ch_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank at default parameters (16 ch, 8-bit counter).
module tb_pwm_bank;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [5:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [NUM_CH-1:0] ch_out;
  logic              period_start;

  int n_checks;
  int n_pass;
  int hi [3];
  int hi_any;
  int ps_n;
  int bad_out;
  int bad_ps;

  pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .ch_out       (ch_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Step to the negedge just after the next period_start pulse, bounded.
  task automatic wait_ps(input string tag, input int limit);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < limit);
    chk(tag, 32'(period_start), 32'd1);
  endtask

  // Sample len cycles; optionally write duty[0] = wd so it lands on the edge after sample wr_at.
  task automatic run(input int len, input int wr_at, input logic [7:0] wd);
    hi[0] = 0; hi[1] = 0; hi[2] = 0; hi_any = 0; ps_n = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (ch_out[0]) hi[0]++;
      if (ch_out[1]) hi[1]++;
      if (ch_out[2]) hi[2]++;
      if (ch_out != '0) hi_any++;
      if (period_start) ps_n++;
      if (wr_at > 0 && i == wr_at) begin
        wr_en = 1'b1; wr_addr = 6'h20; wr_data = wd;
      end
      if (wr_at > 0 && i == wr_at + 1) wr_en = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset hold
    bad_out = 0; bad_ps = 0;
    repeat (5) begin
      @(negedge clk);
      if (ch_out != '0) bad_out++;
      if (period_start) bad_ps++;
    end
    chk("rst_hold_ch_out", 32'(bad_out), 32'd0);
    chk("rst_hold_ps", 32'(bad_ps), 32'd0);
    rst_n = 1'b1;

    // First wrap lands on the 255th edge after release
    run(254, 0, 8'h00);
    chk("pre_wrap_ps", 32'(ps_n), 32'd0);
    chk("pre_wrap_out", 32'(hi_any), 32'd0);
    @(negedge clk);
    chk("first_wrap_ps", 32'(period_start), 32'd1);

    // Static mode
    wr(6'h00, 8'h01);
    chk("static_lat0", 32'(ch_out), 32'h0000);
    @(negedge clk);
    chk("static_on", 32'(ch_out), 32'h0001);
    wr(6'h00, 8'h00);
    chk("static_off_lat", 32'(ch_out), 32'h0001);
    @(negedge clk);
    chk("static_off", 32'(ch_out), 32'h0000);

    // PWM duty 0x80 on ch0
    wr(6'h20, 8'h80);
    wr(6'h04, 8'h01);
    wr(6'h00, 8'h01);
    wait_ps("pwm_sync", 600);
    run(255, 0, 8'h00);
    chk("pwm_hi_ch0", 32'(hi[0]), 32'd128);
    chk("pwm_ps_cnt", 32'(ps_n), 32'd1);
    chk("pwm_ps_end", 32'(period_start), 32'd1);

    // Extremes: ch1 duty 0, ch2 duty MAX
    wr(6'h21, 8'h00);
    wr(6'h22, 8'hFF);
    wr(6'h04, 8'h07);
    wr(6'h00, 8'h07);
    wait_ps("ext_sync", 600);
    run(765, 0, 8'h00);
    chk("ext_ch1_low", 32'(hi[1]), 32'd0);
    chk("ext_ch2_high", 32'(hi[2]), 32'd765);
    chk("ext_ch0", 32'(hi[0]), 32'd384);
    chk("ext_ps_cnt", 32'(ps_n), 32'd3);

    // Shadowing
    wr(6'h20, 8'h40);
    wait_ps("shd_sync", 600);
    run(255, 100, 8'hC0);
    chk("shd_cur_period", 32'(hi[0]), 32'd64);
    run(255, 0, 8'h00);
    chk("shd_next_period", 32'(hi[0]), 32'd192);
    run(255, 254, 8'h10);
    chk("shd_bnd_same", 32'(hi[0]), 32'd192);
    run(255, 0, 8'h00);
    chk("shd_bnd_after", 32'(hi[0]), 32'd192);
    run(255, 0, 8'h00);
    chk("shd_bnd_applied", 32'(hi[0]), 32'd16);

    // Prescale 3
    wr(6'h08, 8'h03);
    wr(6'h20, 8'h80);
    wait_ps("psc_sync", 3000);
    run(1020, 0, 8'h00);
    chk("psc_hi_ch0", 32'(hi[0]), 32'd512);
    chk("psc_ps_cnt", 32'(ps_n), 32'd1);
    chk("psc_ps_end", 32'(period_start), 32'd1);

    // Reset mid-period at count 50
    repeat (200) @(negedge clk);
    chk("mid_ch0_high", 32'(ch_out[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(ch_out), 32'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(255, 0, 8'h00);
    chk("post_rst_period", 32'(ps_n), 32'd1);
    chk("post_rst_ps_end", 32'(period_start), 32'd1);
    chk("post_rst_out", 32'(hi_any), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
